can_tx_arbiter: RTL and testbench

- Transmit-side arbitration controller for the CAN node: chooses one of N_MBOX pending transmit mailboxes and drives SOF, identifier and RTR onto the bus with bit stuffing.
- Performs CAN bitwise arbitration against the bus readback, then hands the bus to the frame serializer.
- Sits between the mailbox registers and the TX framer, in parallel with can_rx / can_destuff on the receive side.
- One Clock_SP cycle equals one bit time, using the same sample-point clock as the receive path.

---
 rtl/can_pkg.sv | 16 +
 rtl/can_tx_select.sv | 35 +++
 rtl/can_tx_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_can_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared state encoding and bus-level constants for the CAN transmit path
package can_pkg;

   typedef enum logic [2:0] {
      IDLE_WAIT,
      READY,
      ARB,
      FRAME,
      RX
   } state_e;

   localparam logic CAN_DOMINANT  = 1'b0;
   localparam logic CAN_RECESSIVE = 1'b1;
   localparam int   STD_ID_W      = 11;

endpackage

// File: rtl/can_tx_select.sv
// rtl/can_tx_select.sv - picks the pending mailbox with the lowest {Id, Rtr} arbitration word
module can_tx_select
   import can_pkg::*;
#(
   parameter int N_MBOX = 4,
   parameter int ID_W   = STD_ID_W
) (
   input  logic [N_MBOX-1:0]      req_i,
   input  logic [N_MBOX*ID_W-1:0] id_flat_i,
   input  logic [N_MBOX-1:0]      rtr_i,
   output logic [N_MBOX-1:0]      winner_o,
   output logic [ID_W:0]          word_o,
   output logic                   valid_o
);

   logic [ID_W:0] key;

   // Strict less-than keeps the earlier (lower index) mailbox on a tie.
   always_comb begin
      winner_o = '0;
      word_o   = '1;
      valid_o  = 1'b0;
      key      = '0;
      for (int i = 0; i < N_MBOX; i++) begin
         key = {id_flat_i[i*ID_W +: ID_W], rtr_i[i]};
         if (req_i[i] && (!valid_o || key < word_o)) begin
            winner_o    = '0;
            winner_o[i] = 1'b1;
            word_o      = key;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/can_tx_arbiter.sv
// rtl/can_tx_arbiter.sv - transmit arbitration: idle detect, SOF/ID/RTR with stuffing, bus readback compare
module can_tx_arbiter
   import can_pkg::*;
#(
   parameter int N_MBOX    = 4,
   parameter int ID_W      = STD_ID_W,
   parameter int IDLE_BITS = 11,
   parameter int STUFF_LEN = 5
) (
   input  logic                   clock_sp_i,
   input  logic                   reset_n_i,
   input  logic [N_MBOX-1:0]      req_i,
   input  logic [N_MBOX*ID_W-1:0] id_flat_i,
   input  logic [N_MBOX-1:0]      rtr_i,
   input  logic                   bus_rx_i,
   input  logic                   frame_done_i,
   input  logic                   frame_error_i,
   output logic                   tx_bit_o,
   output logic [N_MBOX-1:0]      grant_o,
   output logic                   handoff_o,
   output logic [2:0]             stuff_cnt_o,
   output logic                   last_bit_o,
   output logic                   lost_arb_o,
   output logic                   bit_err_o,
   output logic [N_MBOX-1:0]      done_o,
   output logic                   busy_o
);

   localparam int IC_W  = $clog2(IDLE_BITS + 1);
   localparam int IDX_W = $clog2(ID_W + 2);

   state_e              state_q;
   logic [IC_W-1:0]     idle_cnt_q;
   logic [ID_W:0]       word_q;
   logic [IDX_W-1:0]    cur_idx_q;
   logic                stuff_q;
   logic [2:0]          run_q;
   logic                tx_bit_q;
   logic [N_MBOX-1:0]   grant_q;
   logic                handoff_q;
   logic [2:0]          stuff_cnt_q;
   logic                last_bit_q;
   logic                lost_arb_q;
   logic                bit_err_q;
   logic [N_MBOX-1:0]   done_q;
   logic                busy_q;

   logic [N_MBOX-1:0]   win_onehot;
   logic [ID_W:0]       win_word;
   logic                win_valid;
   logic [ID_W:0]       word_sh;
   logic                nxt_bit;

   can_tx_select #(
      .N_MBOX (N_MBOX),
      .ID_W   (ID_W)
   ) u_select (
      .req_i     (req_i),
      .id_flat_i (id_flat_i),
      .rtr_i     (rtr_i),
      .winner_o  (win_onehot),
      .word_o    (win_word),
      .valid_o   (win_valid)
   );

   // cur_idx_q is the data bit on the wire (0 = SOF); the next one sits at the MSB after shifting.
   assign word_sh = word_q << cur_idx_q;
   assign nxt_bit = word_sh[ID_W];

   always_ff @(posedge clock_sp_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE_WAIT;
         idle_cnt_q  <= '0;
         word_q      <= '0;
         cur_idx_q   <= '0;
         stuff_q     <= 1'b0;
         run_q       <= '0;
         tx_bit_q    <= CAN_RECESSIVE;
         grant_q     <= '0;
         handoff_q   <= 1'b0;
         stuff_cnt_q <= '0;
         last_bit_q  <= CAN_RECESSIVE;
         lost_arb_q  <= 1'b0;
         bit_err_q   <= 1'b0;
         done_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         handoff_q  <= 1'b0;
         lost_arb_q <= 1'b0;
         bit_err_q  <= 1'b0;
         done_q     <= '0;
         case (state_q)
            IDLE_WAIT: begin
               if (bus_rx_i) begin
                  if (idle_cnt_q == IC_W'(IDLE_BITS - 1)) begin
                     idle_cnt_q <= '0;
                     state_q    <= READY;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + 1'b1;
                  end
               end else begin
                  idle_cnt_q <= '0;
               end
            end
            READY: begin
               if (!bus_rx_i) begin
                  state_q <= RX;
               end else if (win_valid) begin
                  grant_q   <= win_onehot;
                  word_q    <= win_word;
                  tx_bit_q  <= CAN_DOMINANT;
                  cur_idx_q <= '0;
                  stuff_q   <= 1'b0;
                  run_q     <= 3'd1;
                  busy_q    <= 1'b1;
                  state_q   <= ARB;
               end
            end
            ARB: begin
               if (tx_bit_q == CAN_RECESSIVE && bus_rx_i == CAN_DOMINANT) begin
                  lost_arb_q <= 1'b1;
                  tx_bit_q   <= CAN_RECESSIVE;
                  grant_q    <= '0;
                  busy_q     <= 1'b0;
                  state_q    <= RX;
               end else if (tx_bit_q == CAN_DOMINANT && bus_rx_i == CAN_RECESSIVE) begin
                  bit_err_q  <= 1'b1;
                  tx_bit_q   <= CAN_RECESSIVE;
                  grant_q    <= '0;
                  busy_q     <= 1'b0;
                  idle_cnt_q <= '0;
                  state_q    <= IDLE_WAIT;
               end else if (!stuff_q && cur_idx_q == IDX_W'(ID_W + 1)) begin
                  // RTR echoed back intact; any pending stuff bit is the framer's job.
                  handoff_q   <= 1'b1;
                  stuff_cnt_q <= run_q;
                  last_bit_q  <= tx_bit_q;
                  tx_bit_q    <= CAN_RECESSIVE;
                  state_q     <= FRAME;
               end else if (run_q == 3'(STUFF_LEN)) begin
                  tx_bit_q <= ~tx_bit_q;
                  stuff_q  <= 1'b1;
                  run_q    <= 3'd1;
               end else begin
                  tx_bit_q  <= nxt_bit;
                  cur_idx_q <= cur_idx_q + 1'b1;
                  stuff_q   <= 1'b0;
                  run_q     <= (nxt_bit == tx_bit_q) ? run_q + 3'd1 : 3'd1;
               end
            end
            FRAME: begin
               tx_bit_q <= CAN_RECESSIVE;
               if (frame_done_i) begin
                  done_q     <= grant_q;
                  grant_q    <= '0;
                  busy_q     <= 1'b0;
                  idle_cnt_q <= '0;
                  state_q    <= IDLE_WAIT;
               end else if (frame_error_i) begin
                  grant_q    <= '0;
                  busy_q     <= 1'b0;
                  idle_cnt_q <= '0;
                  state_q    <= IDLE_WAIT;
               end
            end
            RX: begin
               // The recessive sample that ends the foreign frame already counts as idle bit one.
               if (bus_rx_i) begin
                  idle_cnt_q <= IC_W'(1);
                  state_q    <= IDLE_WAIT;
               end
            end
            default: begin
               state_q <= IDLE_WAIT;
            end
         endcase
      end
   end

   assign tx_bit_o    = tx_bit_q;
   assign grant_o     = grant_q;
   assign handoff_o   = handoff_q;
   assign stuff_cnt_o = stuff_cnt_q;
   assign last_bit_o  = last_bit_q;
   assign lost_arb_o  = lost_arb_q;
   assign bit_err_o   = bit_err_q;
   assign done_o      = done_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// tb/tb_can_tx_arbiter.sv - directed bench for can_tx_arbiter with a loopback bus and bit scoreboard
module tb_can_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [43:0] id_flat;
   logic [3:0]  rtr;
   logic        bus_rx;
   logic        frame_done;
   logic        frame_error;
   logic        tx_bit;
   logic [3:0]  grant;
   logic        handoff;
   logic [2:0]  stuff_cnt;
   logic        last_bit;
   logic        lost_arb;
   logic        bit_err;
   logic [3:0]  done;
   logic        busy;

   logic        loop_en;
   logic        force_dom;

   int          checks   = 0;
   int          failures = 0;
   logic        exp_bits[$];
   int          exp_cnt;
   logic        exp_last;

   always #5 clk = ~clk;

   // Wired-AND bus: our own drive echoes back unless something forces dominant.
   assign bus_rx = (loop_en ? tx_bit : 1'b1) & ~force_dom;

   can_tx_arbiter dut (
      .clock_sp_i    (clk),
      .reset_n_i     (reset_n),
      .req_i         (req),
      .id_flat_i     (id_flat),
      .rtr_i         (rtr),
      .bus_rx_i      (bus_rx),
      .frame_done_i  (frame_done),
      .frame_error_i (frame_error),
      .tx_bit_o      (tx_bit),
      .grant_o       (grant),
      .handoff_o     (handoff),
      .stuff_cnt_o   (stuff_cnt),
      .last_bit_o    (last_bit),
      .lost_arb_o    (lost_arb),
      .bit_err_o     (bit_err),
      .done_o        (done),
      .busy_o        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_sof(input string tag, input int expn);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_bit !== 1'b0 && n < 40);
      chk({tag, "_sof_cycles"}, n, expn);
   endtask

   // Called at the SOF sample; expected wire bits come from the stuffing rule applied to {SOF, word}.
   task automatic run_frame(input string tag, input logic [11:0] word, input logic [3:0] gexp);
      logic [12:0] raw;
      logic        last;
      int          run;
      raw = {1'b0, word};
      exp_bits.delete();
      run  = 0;
      last = 1'b1;
      for (int i = 12; i >= 0; i--) begin
         if (run == 5) begin
            exp_bits.push_back(~last);
            last = ~last;
            run  = 1;
         end
         if (run != 0 && raw[i] == last) run++;
         else run = 1;
         last = raw[i];
         exp_bits.push_back(raw[i]);
      end
      exp_cnt  = run;
      exp_last = last;
      chk({tag, "_grant"}, grant, gexp);
      while (exp_bits.size() > 0) begin
         chk({tag, "_bit"}, tx_bit, exp_bits.pop_front());
         @(negedge clk);
      end
      chk({tag, "_handoff"}, handoff, 1);
      chk({tag, "_stuff_cnt"}, stuff_cnt, exp_cnt);
      chk({tag, "_last_bit"}, last_bit, exp_last);
      chk({tag, "_frame_tx"}, tx_bit, 1);
      chk({tag, "_frame_busy"}, busy, 1);
      @(negedge clk);
      chk({tag, "_handoff_pulse"}, handoff, 0);
      chk({tag, "_frame_grant"}, grant, gexp);
   endtask

   task automatic done_pulse(input string tag, input logic [3:0] dexp);
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      chk({tag, "_done"}, done, dexp);
      chk({tag, "_grant_clr"}, grant, 0);
      chk({tag, "_busy_clr"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      reset_n     = 1'b0;
      req         = '0;
      id_flat     = '0;
      rtr         = '0;
      frame_done  = 1'b0;
      frame_error = 1'b0;
      loop_en     = 1'b1;
      force_dom   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tx", tx_bit, 1);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stuff_cnt", stuff_cnt, 0);
      chk("rst_last_bit", last_bit, 1);
      chk("rst_pulses", {handoff, lost_arb, bit_err, done}, 0);
      reset_n = 1'b1;

      // Two requesters, lower identifier wins; Req drop during FRAME must not abort.
      req            = 4'b0011;
      id_flat[0+:11] = 11'h123;
      id_flat[11+:11] = 11'h122;
      wait_sof("t1", 12);
      run_frame("t1", {11'h122, 1'b0}, 4'b0010);
      req = '0;
      repeat (3) @(negedge clk);
      chk("t1_hold_grant", grant, 4'b0010);
      chk("t1_hold_busy", busy, 1);
      done_pulse("t1", 4'b0010);

      // Stray Frame_Done while idle is ignored; then an all-dominant word needing two stuff bits.
      req            = 4'b0001;
      id_flat[0+:11] = 11'h000;
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      chk("stray_done", done, 0);
      wait_sof("t2", 10);
      run_frame("t2", 12'h000, 4'b0001);
      done_pulse("t2", 4'b0001);

      // RTR closes a run of five; then Frame_Error forces a retry.
      id_flat[0+:11] = 11'h00F;
      rtr[0]         = 1'b1;
      wait_sof("t3", 11);
      run_frame("t3", {11'h00F, 1'b1}, 4'b0001);
      frame_error = 1'b1;
      @(negedge clk);
      frame_error = 1'b0;
      chk("t3_err_grant", grant, 0);
      chk("t3_err_busy", busy, 0);
      wait_sof("t3r", 12);
      run_frame("t3r", {11'h00F, 1'b1}, 4'b0001);
      done_pulse("t3r", 4'b0001);

      // Lost arbitration on the ID MSB, foreign frame, then retry.
      id_flat[0+:11] = 11'h400;
      rtr[0]         = 1'b0;
      wait_sof("t4", 11);
      chk("t4_grant", grant, 4'b0001);
      @(negedge clk);
      chk("t4_msb", tx_bit, 1);
      force_dom = 1'b1;
      @(negedge clk);
      chk("t4_lost", lost_arb, 1);
      chk("t4_tx", tx_bit, 1);
      chk("t4_grant_clr", grant, 0);
      chk("t4_busy", busy, 0);
      @(negedge clk);
      chk("t4_lost_pulse", lost_arb, 0);
      chk("t4_rx_tx", tx_bit, 1);
      force_dom = 1'b0;
      wait_sof("t4r", 12);
      run_frame("t4r", {11'h400, 1'b0}, 4'b0001);
      done_pulse("t4r", 4'b0001);

      // Equal identifiers: dominant RTR wins, then a full tie goes to the lower index.
      req             = 4'b0101;
      id_flat[0+:11]  = 11'h0F0;
      id_flat[22+:11] = 11'h0F0;
      rtr             = 4'b0001;
      wait_sof("t5a", 11);
      run_frame("t5a", {11'h0F0, 1'b0}, 4'b0100);
      done_pulse("t5a", 4'b0100);
      rtr = 4'b0000;
      wait_sof("t5b", 11);
      run_frame("t5b", {11'h0F0, 1'b0}, 4'b0001);
      done_pulse("t5b", 4'b0001);

      // Bus stuck recessive under SOF gives a bit error and a retry.
      req            = 4'b0001;
      id_flat[0+:11] = 11'h123;
      loop_en        = 1'b0;
      wait_sof("t6", 11);
      @(negedge clk);
      chk("t6_bit_err", bit_err, 1);
      chk("t6_tx", tx_bit, 1);
      chk("t6_grant", grant, 0);
      chk("t6_busy", busy, 0);
      @(negedge clk);
      chk("t6_bit_err_pulse", bit_err, 0);
      wait_sof("t6r", 11);
      loop_en = 1'b1;
      run_frame("t6r", {11'h123, 1'b0}, 4'b0001);
      done_pulse("t6r", 4'b0001);

      // Asynchronous reset while driving a dominant ID bit releases the bus at once.
      wait_sof("t7", 11);
      @(negedge clk);
      chk("t7_pre_tx", tx_bit, 0);
      reset_n = 1'b0;
      #1;
      chk("t7_rst_tx", tx_bit, 1);
      chk("t7_rst_grant", grant, 0);
      chk("t7_rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
